// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_control
// Description : Control FSM for a multicycle MIPS datapath. Walks each
//               instruction through fetch/decode/execute/memory/writeback,
//               stalls on Avalon waitrequest and halts on JR to address 0.
//               Outputs are decoded combinationally from state/opcode/funct.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       waitrequest,
  input  logic       alu_zero,
  input  logic       jr_target_zero,
  output logic       active,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDIU = 6'b001001;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;
  localparam logic [5:0] c_OP_SLTIU = 6'b001011;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_XORI  = 6'b001110;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_FN_JR    = 6'b001000;

  state_t state_q;
  state_t state_d;
  logic   active_q;
  logic   active_d;

  logic w_is_rtype;
  logic w_is_jr;
  logic w_is_ialu;
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_beq;
  logic w_is_bne;
  logic w_is_j;
  logic w_is_jal;

  // Instruction class decode from opcode/funct
  always_comb begin
    w_is_rtype = (opcode == c_OP_RTYPE) && (funct != c_FN_JR);
    w_is_jr    = (opcode == c_OP_RTYPE) && (funct == c_FN_JR);
    w_is_ialu  = (opcode == c_OP_ADDIU) || (opcode == c_OP_SLTI) ||
                 (opcode == c_OP_SLTIU) || (opcode == c_OP_ANDI) ||
                 (opcode == c_OP_ORI)   || (opcode == c_OP_XORI) ||
                 (opcode == c_OP_LUI);
    w_is_lw    = (opcode == c_OP_LW);
    w_is_sw    = (opcode == c_OP_SW);
    w_is_beq   = (opcode == c_OP_BEQ);
    w_is_bne   = (opcode == c_OP_BNE);
    w_is_j     = (opcode == c_OP_J);
    w_is_jal   = (opcode == c_OP_JAL);
  end

  // Next-state and datapath control decode; reset forces every line low
  always_comb begin
    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    pc_source  = 2'd0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    reg_write  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          iord     = 1'b0;
          if (!waitrequest) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_a = 1'b0;
            alu_src_b = 2'd1;
            alu_op    = 2'd0;
            pc_source = 2'd0;
            state_d   = S_DECODE;
          end
        end
        S_DECODE: begin
          // Speculative branch target PC + (imm<<2) lands in ALUOut
          alu_src_a = 1'b0;
          alu_src_b = 2'd3;
          alu_op    = 2'd0;
          state_d   = S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          if (w_is_rtype) begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd0;
            alu_op    = 2'd2;
            state_d   = S_WB;
          end else if (w_is_jr) begin
            if (jr_target_zero) begin
              state_d = S_HALT;
            end else begin
              pc_write  = 1'b1;
              pc_source = 2'd3;
            end
          end else if (w_is_ialu) begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_op    = 2'd3;
            state_d   = S_WB;
          end else if (w_is_lw || w_is_sw) begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_op    = 2'd0;
            state_d   = S_MEM;
          end else if (w_is_beq || w_is_bne) begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd0;
            alu_op    = 2'd1;
            pc_source = 2'd1;
            pc_write  = (w_is_beq & alu_zero) | (w_is_bne & ~alu_zero);
          end else if (w_is_j || w_is_jal) begin
            pc_write  = 1'b1;
            pc_source = 2'd2;
            if (w_is_jal) begin
              // PC already holds the return address (+4 done in fetch)
              reg_write  = 1'b1;
              reg_dst    = 2'd2;
              mem_to_reg = 2'd2;
            end
          end
        end
        S_MEM: begin
          iord      = 1'b1;
          mem_read  = w_is_lw;
          mem_write = w_is_sw;
          if (!waitrequest) begin
            state_d = w_is_lw ? S_WB : S_FETCH;
          end
        end
        S_WB: begin
          state_d = S_FETCH;
          if (w_is_rtype) begin
            reg_write  = 1'b1;
            reg_dst    = 2'd1;
            mem_to_reg = 2'd0;
          end else if (w_is_ialu) begin
            reg_write  = 1'b1;
            reg_dst    = 2'd0;
            mem_to_reg = 2'd0;
          end else if (w_is_lw) begin
            reg_write  = 1'b1;
            reg_dst    = 2'd0;
            mem_to_reg = 2'd1;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // Active flag drops on the edge that enters HALT and stays low until reset
  always_comb begin
    active_d = (state_d != S_HALT);
  end

  // State and active-flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      active_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
    end
  end

  assign state  = state_q;
  assign active = active_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_control
// Description : Self-checking bench for mips_multicycle_control. Each cycle
//               pushes the expected control vector into a scoreboard queue
//               and pops it against the DUT outputs on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       waitrequest;
  logic       alu_zero;
  logic       jr_target_zero;
  logic       active;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic [2:0] state;

  int n_vec;
  int n_err;
  logic [20:0] r_sb_q[$];
  logic [20:0] w_obs;

  mips_multicycle_control u_dut (
    .clk            (clk),
    .reset          (reset),
    .opcode         (opcode),
    .funct          (funct),
    .waitrequest    (waitrequest),
    .alu_zero       (alu_zero),
    .jr_target_zero (jr_target_zero),
    .active         (active),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .iord           (iord),
    .ir_write       (ir_write),
    .pc_write       (pc_write),
    .alu_src_a      (alu_src_a),
    .alu_src_b      (alu_src_b),
    .alu_op         (alu_op),
    .pc_source      (pc_source),
    .reg_dst        (reg_dst),
    .mem_to_reg     (mem_to_reg),
    .reg_write      (reg_write),
    .state          (state)
  );

  // Observed vector layout:
  // {state, active, mem_read, mem_write, iord, ir_write, pc_write,
  //  alu_src_a, alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg, reg_write}
  assign w_obs = {state, active, mem_read, mem_write, iord, ir_write, pc_write,
                  alu_src_a, alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg,
                  reg_write};

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench always ends
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

  function automatic logic [20:0] mk(input logic [2:0] st, input logic act,
      input logic mr, input logic mw, input logic io, input logic irw,
      input logic pcw, input logic a, input logic [1:0] b, input logic [1:0] op,
      input logic [1:0] pcs, input logic [1:0] rd, input logic [1:0] m2r,
      input logic rw);
    return {st, act, mr, mw, io, irw, pcw, a, b, op, pcs, rd, m2r, rw};
  endfunction

  function automatic logic [20:0] e_fetch();
    return mk(3'd0, 1, 1, 0, 0, 1, 1, 0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 0);
  endfunction

  function automatic logic [20:0] e_fetch_stall();
    return mk(3'd0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
  endfunction

  function automatic logic [20:0] e_decode();
    return mk(3'd1, 1, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 0);
  endfunction

  function automatic logic [20:0] e_idle(input logic [2:0] st, input logic act);
    return mk(st, act, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
  endfunction

  task automatic check_vec(input string tag, input logic [20:0] obs,
                           input logic [20:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %06h expected %06h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, compare on falling edge
  task automatic cyc(input string tag, input logic wr, input logic az,
                     input logic jz, input logic rst, input logic [20:0] e);
    reset          = rst;
    waitrequest    = wr;
    alu_zero       = az;
    jr_target_zero = jz;
    r_sb_q.push_back(e);
    @(negedge clk);
    if (r_sb_q.size() != 0) begin
      check_vec(tag, w_obs, r_sb_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    reset          = 1'b1;
    opcode         = 6'd0;
    funct          = 6'd0;
    waitrequest    = 1'b0;
    alu_zero       = 1'b0;
    jr_target_zero = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ADDU: 0,1,2,4
    set_instr(6'b000000, 6'b100001);
    cyc("addu_fetch", 0, 0, 0, 0, e_fetch());
    cyc("addu_decode", 0, 0, 0, 0, e_decode());
    cyc("addu_exec", 0, 0, 0, 0, mk(3'd2, 1, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 0));
    cyc("addu_wb", 0, 0, 0, 0, mk(3'd4, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1));

    // LW with two wait cycles in MEM: 7 cycles total
    set_instr(6'b100011, 6'd0);
    cyc("lw_fetch", 0, 0, 0, 0, e_fetch());
    cyc("lw_decode", 0, 0, 0, 0, e_decode());
    cyc("lw_exec", 0, 0, 0, 0, mk(3'd2, 1, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 0));
    for (int i = 0; i < 2; i++) begin
      cyc("lw_mem_wait", 1, 0, 0, 0, mk(3'd3, 1, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
    end
    cyc("lw_mem_go", 0, 0, 0, 0, mk(3'd3, 1, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
    cyc("lw_wb", 0, 0, 0, 0, mk(3'd4, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 1));

    // Branches: BEQ taken/not, BNE taken/not
    for (int k = 0; k < 4; k++) begin
      logic z;
      logic take;
      z    = k[0];
      set_instr((k < 2) ? 6'b000100 : 6'b000101, 6'd0);
      take = (k < 2) ? z : ~z;
      cyc("br_fetch", 0, 0, 0, 0, e_fetch());
      cyc("br_decode", 0, 0, 0, 0, e_decode());
      cyc((k < 2) ? "beq_exec" : "bne_exec", 0, z, 0, 0,
          mk(3'd2, 1, 0, 0, 0, 0, take, 1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 0));
    end

    // Fetch stall then J
    set_instr(6'b000010, 6'd0);
    cyc("fetch_stall", 1, 0, 0, 0, e_fetch_stall());
    cyc("j_fetch", 0, 0, 0, 0, e_fetch());
    cyc("j_decode", 0, 0, 0, 0, e_decode());
    cyc("j_exec", 0, 0, 0, 0, mk(3'd2, 1, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 0));

    // JAL
    set_instr(6'b000011, 6'd0);
    cyc("jal_fetch", 0, 0, 0, 0, e_fetch());
    cyc("jal_decode", 0, 0, 0, 0, e_decode());
    cyc("jal_exec", 0, 0, 0, 0, mk(3'd2, 1, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 1));

    // ORI (I-type ALU)
    set_instr(6'b001101, 6'd0);
    cyc("ori_fetch", 0, 0, 0, 0, e_fetch());
    cyc("ori_decode", 0, 0, 0, 0, e_decode());
    cyc("ori_exec", 0, 0, 0, 0, mk(3'd2, 1, 0, 0, 0, 0, 0, 1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 0));
    cyc("ori_wb", 0, 0, 0, 0, mk(3'd4, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1));

    // SW, no stall
    set_instr(6'b101011, 6'd0);
    cyc("sw_fetch", 0, 0, 0, 0, e_fetch());
    cyc("sw_decode", 0, 0, 0, 0, e_decode());
    cyc("sw_exec", 0, 0, 0, 0, mk(3'd2, 1, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 0));
    cyc("sw_mem", 0, 0, 0, 0, mk(3'd3, 1, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));

    // SW with reset asserted while in MEM (strobe would otherwise be up)
    cyc("swr_fetch", 0, 0, 0, 0, e_fetch());
    cyc("swr_decode", 0, 0, 0, 0, e_decode());
    cyc("swr_exec", 0, 0, 0, 0, mk(3'd2, 1, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 0));
    cyc("swr_mem_reset", 1, 0, 0, 1, e_idle(3'd3, 1));

    // Unknown opcode: no effect, back to FETCH
    set_instr(6'b111111, 6'd0);
    cyc("unk_fetch", 0, 0, 0, 0, e_fetch());
    cyc("unk_decode", 0, 0, 0, 0, e_decode());
    cyc("unk_exec", 0, 0, 0, 0, e_idle(3'd2, 1));

    // JR to nonzero target
    set_instr(6'b000000, 6'b001000);
    cyc("jr_fetch", 0, 0, 0, 0, e_fetch());
    cyc("jr_decode", 0, 0, 0, 0, e_decode());
    cyc("jr_exec", 0, 0, 0, 0, mk(3'd2, 1, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 0));

    // JR to zero: halt, sticky until reset
    cyc("jrz_fetch", 0, 0, 1, 0, e_fetch());
    cyc("jrz_decode", 0, 0, 1, 0, e_decode());
    cyc("jrz_exec", 0, 0, 1, 0, e_idle(3'd2, 1));
    for (int i = 0; i < 12; i++) begin
      cyc("halt", i[0], i[1], 1, 0, e_idle(3'd5, 0));
    end
    cyc("halt_reset", 0, 0, 0, 1, e_idle(3'd5, 0));
    set_instr(6'b000000, 6'b100001);
    cyc("post_reset_fetch", 0, 0, 0, 0, e_fetch());
    cyc("post_reset_decode", 0, 0, 0, 0, e_decode());

    if (r_sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", r_sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
